sram_mem_responder: RTL and testbench
=====================================

Name: sram_mem_responder

Overview:
- Responder for the MEM stage's data-memory requests: accepts one 32-bit read or write per transaction.
- Performs the access as two 16-bit halfword cycles on an external asynchronous SRAM.
- Holds ready low while busy, so the CPU top freezes every pipeline stage until the access completes.
- Sits between the MEM stage and the off-chip SRAM pins.

Parameters:
- BASE_ADDR, 1024: CPU byte address that maps to SRAM word 0.
- SRAM_AW, 18: SRAM halfword address width.
- WAIT_CYCLES, 2: cycles each halfword phase is held; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- rd_en  input  1  MEM-stage read request, held until ready is high.
- wr_en  input  1  MEM-stage write request, held until ready is high.
- addr  input  32  byte address, the ALU result.
- wdata  input  32  store data (Val_Rm).
- rdata  output  32  load data, valid in the DONE cycle and held afterwards.
- ready  output  1  high means the request is complete or no request is pending; low means freeze the pipeline.
- sram_addr  output  SRAM_AW  halfword address.
- sram_dq_out  output  16  write data to the pad.
- sram_dq_oe  output  1  pad output enable.
- sram_dq_in  input  16  read data from the pad.
- sram_we_n  output  1  SRAM write strobe, active low.
- sram_oe_n  output  1  SRAM output enable, active low.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0, rdata=0.
  - sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
- Request and ready:
  - req = rd_en | wr_en. If both are asserted, the access is a write.
  - ready = ~req | (state==DONE), combinational. With no request, ready=1 in every state.
- Address mapping:
  - word = (addr - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits, so out-of-window addresses wrap.
  - addr[1:0] is ignored.
  - Low halfword address = {word,0}; high halfword address = {word,1}.
- State machine, with a wait counter cnt:
  - IDLE: if req, latch op, word and wdata; cnt=0; go to LO. Otherwise stay in IDLE.
  - LO: drive sram_addr={word,0}.
    - Write: sram_dq_out=wdata[15:0], sram_dq_oe=1, sram_we_n=0.
    - Read: sram_oe_n=0, and rdata[15:0] is captured from sram_dq_in on the cycle where cnt==WAIT_CYCLES-1.
    - After WAIT_CYCLES cycles: cnt=0, go to HI.
  - HI: same as LO, using {word,1} and bits [31:16].
  - DONE: one cycle; ready=1, SRAM strobes inactive; go to IDLE.
- Latency, with t0 = the IDLE cycle in which req is first seen:
  - ready is low for cycles t0..t0+2W and high at t0+2W+1 (the DONE cycle); W = WAIT_CYCLES.
  - Default W=2: ready is low for 5 cycles.
- Back-to-back: the pipeline advances on the DONE edge. A new request present in the following IDLE cycle starts immediately, with one idle cycle between accesses.
- Write strobe: sram_we_n rises to 1 between LO and HI for exactly one cycle (the first HI cycle stays strobe-inactive), and the address changes only while we_n is high.
- Request dropped mid-access:
  - The access completes regardless (the latched op is used).
  - ready reports ~req, so it may already be high; this is a protocol violation but harmless.
- Reset mid-access: asynchronous return to IDLE with all strobes inactive. A partial write may leave the SRAM word half-updated; this is acceptable.
- rdata is untouched by writes.

Decomposition:
- Shared package holds:
  - state enum {IDLE, LO, HI, DONE} (2 bits);
  - default constants BASE_ADDR=1024, SRAM_AW=18, WAIT_CYCLES=2;
  - SRAM_DW=16.
- Single module; the wait counter stays inline, and no sub-module is warranted.
- The testbench supplies a behavioural SRAM model, sram_model, that responds to sram_addr/we_n/oe_n with zero latency.

Test Plan:
1. Write then read: wr_en, addr=1024, wdata=0xDEADBEEF; then rd_en at addr=1024.
   - SRAM[0]=0xBEEF and SRAM[1]=0xDEAD.
   - Read returns rdata=0xDEADBEEF in the DONE cycle.
   - Each access holds ready low for exactly 5 cycles (W=2).
2. Address mapping: write 0x12345678 to addr=1036.
   - SRAM[6]=0x5678, SRAM[7]=0x1234.
   - Reading addr=1037 returns 0x12345678 (low bits ignored).
3. Back-to-back: three writes held continuously, to 1024, 1028, 1032.
   - Each access has ready low for 5 cycles and high for 1 cycle.
   - Total of 18 cycles; no SRAM write-strobe overlap between address changes.
4. Idle and simultaneous requests:
   - With no request for 10 cycles, ready stays 1 and no strobes toggle.
   - rd_en=wr_en=1 at 1024 with 0xCAFEF00D performs a write.
5. Reset mid-access: assert rst low during HI of a write.
   - Outputs go to their reset values immediately: ready=1 (no request), we_n=1.
   - After release, a new read completes normally with the correct latency.
6. WAIT_CYCLES=1 build: write/read of 0xA5A5_5A5A round-trips, with ready low for 3 cycles per access.

Source files
------------

// File: rtl/sram_mem_responder_pkg.sv
// rtl/sram_mem_responder_pkg.sv - shared constants, state encoding and helpers for sram_mem_responder
// Contents:
//   DEF_* defaults for the responder parameters, SRAM data width, wait counter width,
//   2-bit state constants ST_IDLE/ST_LO/ST_HI/ST_DONE and a halfword select helper.
package sram_mem_responder_pkg;

  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_SRAM_AW     = 18;
  localparam int unsigned DEF_WAIT_CYCLES = 2;
  localparam int unsigned SRAM_DW         = 16;
  localparam int unsigned CNT_W           = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LO   = 2'd1;
  localparam state_t ST_HI   = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  function automatic logic [SRAM_DW-1:0] half_of(input logic [31:0] w, input logic hi);
    return hi ? w[31:16] : w[15:0];
  endfunction

endpackage

// File: rtl/sram_mem_responder.sv
// rtl/sram_mem_responder.sv - MEM-stage data responder doing 32-bit accesses as two SRAM halfword phases
// Ports:
//   clk, rst        : clock (rising edge) and asynchronous active-low reset
//   rd_en, wr_en    : MEM-stage read / write request, held until ready
//   addr, wdata     : byte address and store data
//   rdata           : load data, valid in the DONE cycle and held afterwards
//   ready           : low freezes the pipeline while an access is in flight
//   sram_addr       : halfword address to the SRAM
//   sram_dq_out/oe  : write data and pad output enable
//   sram_dq_in      : read data from the pad
//   sram_we_n/oe_n  : SRAM write strobe and output enable, active low
module sram_mem_responder
  import sram_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic                wr_en,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  output logic                ready,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic [SRAM_DW-1:0]  sram_dq_out,
  output logic                sram_dq_oe,
  input  logic [SRAM_DW-1:0]  sram_dq_in,
  output logic                sram_we_n,
  output logic                sram_oe_n
);

  localparam int unsigned      WORD_W   = SRAM_AW - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  // With a single-cycle HI phase there is no room for a strobe gap, so the
  // high halfword is written in that one cycle.
  localparam logic             HI_GAP   = (WAIT_CYCLES > 1);

  logic              req;
  logic [31:0]       addr_off;
  logic [WORD_W-1:0] addr_word;
  logic              unused_addr_bits;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_wr_q, op_wr_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DW-1:0] dq_out_q, dq_out_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;
  logic               pin_hi;

  assign req = rd_en | wr_en;

  // Out-of-window addresses simply wrap; the byte offset bits are ignored.
  assign addr_off         = addr - BASE_ADDR;
  assign addr_word        = addr_off[SRAM_AW:2];
  assign unused_addr_bits = ^{addr_off[31:SRAM_AW+1], addr_off[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          op_wr_d = wr_en;
          word_d  = addr_word;
          wdata_d = wdata;
          cnt_d   = '0;
          state_d = ST_LO;
        end
      end
      ST_LO: begin
        if (cnt_q == CNT_LAST) begin
          if (!op_wr_q) rdata_d[15:0] = sram_dq_in;
          cnt_d   = '0;
          state_d = ST_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (cnt_q == CNT_LAST) begin
          if (!op_wr_q) rdata_d[31:16] = sram_dq_in;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pins are registered from the next state so the SRAM sees glitch-free
  // strobes that line up with the LO/HI phases of the state machine.
  always_comb begin
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    pin_hi      = (state_d == ST_HI);
    if ((state_d == ST_LO) || (state_d == ST_HI)) begin
      sram_addr_d = {word_d, pin_hi};
      if (op_wr_d) begin
        dq_out_d = half_of(wdata_d, pin_hi);
        dq_oe_d  = 1'b1;
        // First HI cycle keeps we_n high so the address switch never
        // happens inside a write pulse.
        we_n_d   = pin_hi && HI_GAP && (cnt_d == '0);
      end else begin
        oe_n_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_wr_q     <= 1'b0;
      word_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      sram_addr_q <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_wr_q     <= op_wr_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  assign ready       = ~req | (state_q == ST_DONE);
  assign rdata       = rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_sram_mem_responder.sv
// tb/tb_sram_mem_responder.sv - self-checking bench for sram_mem_responder with behavioural SRAMs
module tb_sram_mem_responder;

  localparam logic [31:0] BASE    = 32'd1024;
  localparam int          W       = 2;
  localparam int          DONE_PH = 2*W + 1;
  localparam int          MEM_N   = 262144;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // W=2 instance
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] s_addr;
  logic [15:0] s_dq_out, s_dq_in;
  logic        s_dq_oe, s_we_n, s_oe_n;

  // W=1 instance
  logic        rd_en1 = 1'b0, wr_en1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [31:0] rdata1;
  logic        ready1;
  logic [17:0] t_addr;
  logic [15:0] t_dq_out, t_dq_in;
  logic        t_dq_oe, t_we_n, t_oe_n;

  sram_mem_responder #(.BASE_ADDR(BASE), .SRAM_AW(18), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .sram_addr(s_addr), .sram_dq_out(s_dq_out),
    .sram_dq_oe(s_dq_oe), .sram_dq_in(s_dq_in), .sram_we_n(s_we_n), .sram_oe_n(s_oe_n));

  sram_mem_responder #(.BASE_ADDR(BASE), .SRAM_AW(18), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata1), .ready(ready1), .sram_addr(t_addr), .sram_dq_out(t_dq_out),
    .sram_dq_oe(t_dq_oe), .sram_dq_in(t_dq_in), .sram_we_n(t_we_n), .sram_oe_n(t_oe_n));

  // Behavioural asynchronous SRAMs: zero-latency read, write while we_n is low.
  logic [15:0] mem0 [0:MEM_N-1];
  logic [15:0] mem1 [0:MEM_N-1];
  logic        mem_clr = 1'b1;

  assign s_dq_in = s_oe_n ? 16'h0000 : mem0[s_addr];
  assign t_dq_in = t_oe_n ? 16'h0000 : mem1[t_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEM_N; i++) begin
        mem0[i] <= 16'h0000;
        mem1[i] <= 16'h0000;
      end
    end else begin
      if (!s_we_n) mem0[s_addr] <= s_dq_out;
      if (!t_we_n) mem1[t_addr] <= t_dq_out;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: word-level memory and access timeline counted from t0.
  logic [31:0] ref_mem [int];

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] o;
    o = (a - BASE) >> 2;
    return int'(o & 32'h0001_FFFF);
  endfunction

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  int          m_phase = -1;
  logic        m_wr = 1'b0;
  int          m_word = 0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_last_rdata = '0;
  logic [17:0] prev_addr = '0;
  logic        prev_we_n = 1'b1;
  logic        m_req, m_hi;

  always @(negedge clk) begin
    if (!rst) begin
      m_phase = -1;
      m_last_rdata = '0;
      check("rst_ready", ready, !(rd_en | wr_en));
      check("rst_strobes", {s_we_n, s_oe_n, s_dq_oe}, 3'b110);
    end else begin
      m_req = rd_en | wr_en;
      if (m_phase < 0 && m_req) begin
        m_phase = 0;
        m_wr    = wr_en;
        m_word  = word_of(addr);
        m_wdata = wdata;
      end
      check("ready", ready, (!m_req) || (m_phase == DONE_PH));
      if (m_phase >= 1 && m_phase <= 2*W) begin
        m_hi = (m_phase > W);
        check("pin_addr", s_addr, m_word*2 + int'(m_hi));
        if (m_wr) begin
          check("pin_ctl_wr", {s_we_n, s_oe_n, s_dq_oe}, {(m_phase == W+1) && (W > 1), 1'b1, 1'b1});
          check("pin_dq", s_dq_out, m_hi ? m_wdata[31:16] : m_wdata[15:0]);
        end else begin
          check("pin_ctl_rd", {s_we_n, s_oe_n, s_dq_oe}, 3'b100);
        end
      end else begin
        check("pin_idle", {s_we_n, s_oe_n, s_dq_oe}, 3'b110);
      end
      if (s_addr != prev_addr) check("we_overlap", !s_we_n && !prev_we_n, 1'b0);
      if (m_phase == DONE_PH) begin
        if (m_wr) begin
          ref_mem[m_word] = m_wdata;
        end else begin
          check("rdata", rdata, ref_rd(m_word));
          m_last_rdata = ref_rd(m_word);
        end
        m_phase = -1;
      end else if (m_phase < 0) begin
        check("rdata_hold", rdata, m_last_rdata);
      end else begin
        m_phase++;
      end
    end
    prev_addr = s_addr;
    prev_we_n = s_we_n;
  end

  task automatic access(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rv, output int lows);
    @(posedge clk); #1;
    wr_en = wr; rd_en = rd; addr = a; wdata = d;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready) break;
      lows++;
    end
    check("access_timeout", lows < 100, 1'b1);
    rv = rdata;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic access1(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rv, output int lows);
    @(posedge clk); #1;
    wr_en1 = wr; rd_en1 = !wr; addr1 = a; wdata1 = d;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready1) break;
      lows++;
    end
    check("access1_timeout", lows < 100, 1'b1);
    rv = rdata1;
    @(posedge clk); #1;
    wr_en1 = 1'b0; rd_en1 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] rv;
  int          lows, total;
  logic        ok;
  logic [31:0] ra, rd;
  int          op, sel, k;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", ready, 1'b1);
    check("reset_rdata", rdata, 32'h0);
    check("reset_pins", {s_we_n, s_oe_n, s_dq_oe}, 3'b110);
    check("reset_addr", s_addr, 18'h0);
    check("reset_dq_out", s_dq_out, 16'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    mem_clr = 1'b0;

    // Write then read
    access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, rv, lows);
    check("t1_wr_lows", lows, 5);
    check("t1_mem0", mem0[0], 16'hBEEF);
    check("t1_mem1", mem0[1], 16'hDEAD);
    access(1'b0, 1'b1, 32'd1024, 32'h0, rv, lows);
    check("t1_rd_lows", lows, 5);
    check("t1_rdata", rv, 32'hDEADBEEF);

    // Address mapping, low bits ignored
    access(1'b1, 1'b0, 32'd1036, 32'h12345678, rv, lows);
    check("t2_mem6", mem0[6], 16'h5678);
    check("t2_mem7", mem0[7], 16'h1234);
    access(1'b0, 1'b1, 32'd1037, 32'h0, rv, lows);
    check("t2_rdata", rv, 32'h12345678);

    // Back-to-back writes held continuously
    @(posedge clk); #1;
    wr_en = 1'b1; addr = 32'd1024; wdata = 32'h11110000;
    total = 0;
    for (int n = 0; n < 3; n++) begin
      lows = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        total++;
        if (ready) break;
        lows++;
      end
      check("t3_lows", lows, 5);
      @(posedge clk); #1;
      if (n == 0) begin addr = 32'd1028; wdata = 32'h22220001; end
      else if (n == 1) begin addr = 32'd1032; wdata = 32'h33330002; end
      else wr_en = 1'b0;
    end
    check("t3_total", total, 18);
    check("t3_mem2", mem0[2], 16'h0001);
    check("t3_mem5", mem0[5], 16'h3333);

    // Idle, then simultaneous read+write is a write
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!ready || !s_we_n || !s_oe_n || s_dq_oe) ok = 1'b0;
    end
    check("t4_idle", ok, 1'b1);
    access(1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, rv, lows);
    check("t4_mem0", mem0[0], 16'hF00D);
    check("t4_mem1", mem0[1], 16'hCAFE);
    access(1'b0, 1'b1, 32'd1024, 32'h0, rv, lows);
    check("t4_rdata", rv, 32'hCAFEF00D);

    // Reset during the write pulse of the HI phase
    @(posedge clk); #1;
    wr_en = 1'b1; addr = 32'd1024; wdata = 32'h11112222;
    repeat (4) @(posedge clk);
    #2;
    check("t5_we_before", s_we_n, 1'b0);
    rst = 1'b0; wr_en = 1'b0;
    #1;
    check("t5_ready", ready, 1'b1);
    check("t5_we_n", s_we_n, 1'b1);
    check("t5_ctl", {s_oe_n, s_dq_oe}, 2'b10);
    check("t5_addr", s_addr, 18'h0);
    check("t5_rdata", rdata, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    access(1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, rv, lows);
    access(1'b0, 1'b1, 32'd1036, 32'h0, rv, lows);
    check("t5_rd_lows", lows, 5);
    check("t5_rd_rdata", rv, 32'h12345678);

    // WAIT_CYCLES=1 instance
    access1(1'b1, 32'd1024, 32'hA5A55A5A, rv, lows);
    check("t6_wr_lows", lows, 3);
    check("t6_mem0", mem1[0], 16'h5A5A);
    check("t6_mem1", mem1[1], 16'hA5A5);
    access1(1'b0, 32'd1024, 32'h0, rv, lows);
    check("t6_rd_lows", lows, 3);
    check("t6_rdata", rv, 32'hA5A55A5A);

    // Randomized traffic checked by the reference model
    for (int n = 0; n < 150; n++) begin
      op  = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      ra  = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      if (sel == 0) ra = ra + 32'h0008_0000;
      else if (sel == 1) ra = BASE - 32'(4 * $urandom_range(1, 4));
      rd = $urandom;
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(1, 3);
        @(posedge clk); #1;
        wr_en = (op != 0); rd_en = (op != 1); addr = ra; wdata = rd;
        repeat (k) @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (2*W + 3) @(posedge clk);
      end else begin
        access(op != 0, op != 1, ra, rd, rv, lows);
        check("rand_lows", lows, 2*W + 1);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
